// File: rtl/rb_write_arbiter.sv
// rb_write_arbiter
// Three-way round-robin arbiter that owns the single write port of the
// datapath register bank. Requesters are the writeback path (0), the CMOV
// unit (1) and the HAM unit (2). At most one write is granted per cycle and
// the grant drives registered write-port signals. HALT freezes arbitration.
//
// Ports:
//   clk        system clock, rising edge
//   reset_all  asynchronous active-low reset
//   halt       core HALT, blocks new grants while high
//   req        per-requester write request (bit i = requester i)
//   req_addr   packed destination indices, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   packed write data, requester i at [i*DATA_W +: DATA_W]
//   gnt        registered one-hot grant, one cycle wide
//   rb_we      registered register bank write enable
//   rb_waddr   registered register bank write index
//   rb_wdata   registered register bank write data
//   wr_count   16-bit wrapping count of committed writes
//   idle       high when nothing is granted and no unmasked request pends
module rb_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_all,
  input  logic                  halt,
  input  logic [2:0]            req,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_data,
  output logic [2:0]            gnt,
  output logic                  rb_we,
  output logic [ADDR_W-1:0]     rb_waddr,
  output logic [DATA_W-1:0]     rb_wdata,
  output logic [15:0]           wr_count,
  output logic                  idle
);

  logic [2:0]        r_gnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [15:0]       r_wrCount;
  logic [1:0]        r_last;

  logic [2:0]        w_eff;
  logic [1:0]        w_lastSafe;
  logic [1:0]        w_cand [3];
  logic              w_found;
  logic [1:0]        w_win;
  logic [2:0]        w_winOneHot;
  logic [ADDR_W-1:0] w_selAddr;
  logic [DATA_W-1:0] w_selData;
  logic              w_grant;
  logic              w_addrNonZero;

  // A requester whose grant is visible this cycle is masked so the same
  // addr/data is never written twice.
  assign w_eff = req & ~r_gnt;

  // The pointer should never hold 3; if it ever does, behave as if it were 2.
  assign w_lastSafe = (r_last == 2'd3) ? 2'd2 : r_last;

  // Search order is last+1, last+2, last (mod 3).
  always_comb begin
    w_cand[0] = 2'd1;
    w_cand[1] = 2'd2;
    w_cand[2] = 2'd0;
    case (w_lastSafe)
      2'd0: begin
        w_cand[0] = 2'd1;
        w_cand[1] = 2'd2;
        w_cand[2] = 2'd0;
      end
      2'd1: begin
        w_cand[0] = 2'd2;
        w_cand[1] = 2'd0;
        w_cand[2] = 2'd1;
      end
      default: begin
        w_cand[0] = 2'd0;
        w_cand[1] = 2'd1;
        w_cand[2] = 2'd2;
      end
    endcase
  end

  // First effective request in search order wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!w_found && w_eff[w_cand[k]]) begin
        w_found = 1'b1;
        w_win   = w_cand[k];
      end
    end
  end

  // Route the winner's address and data to the write-port registers.
  always_comb begin
    case (w_win)
      2'd1: begin
        w_selAddr = req_addr[ADDR_W +: ADDR_W];
        w_selData = req_data[DATA_W +: DATA_W];
      end
      2'd2: begin
        w_selAddr = req_addr[2*ADDR_W +: ADDR_W];
        w_selData = req_data[2*DATA_W +: DATA_W];
      end
      default: begin
        w_selAddr = req_addr[ADDR_W-1:0];
        w_selData = req_data[DATA_W-1:0];
      end
    endcase
  end

  assign w_winOneHot   = 3'b001 << w_win;
  assign w_grant       = !halt && w_found;
  // Index 0 is hardwired zero: the grant still consumes the request but the
  // write itself is dropped and not counted.
  assign w_addrNonZero = (w_selAddr != '0);

  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      r_gnt     <= 3'b000;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wrCount <= 16'h0000;
      r_last    <= 2'd2;
    end else if (w_grant) begin
      r_gnt   <= w_winOneHot;
      r_we    <= w_addrNonZero;
      r_waddr <= w_selAddr;
      r_wdata <= w_selData;
      r_last  <= w_win;
      if (w_addrNonZero) begin
        r_wrCount <= r_wrCount + 16'd1;
      end
    end else begin
      r_gnt <= 3'b000;
      r_we  <= 1'b0;
    end
  end

  assign gnt      = r_gnt;
  assign rb_we    = r_we;
  assign rb_waddr = r_waddr;
  assign rb_wdata = r_wdata;
  assign wr_count = r_wrCount;
  assign idle     = (r_gnt == 3'b000) && (w_eff == 3'b000);

endmodule

// File: tb/tb_rb_write_arbiter.sv
// Testbench for rb_write_arbiter: directed scenarios plus a randomized run,
// all checked against a behavioural model of the arbitration rules.
module tb_rb_write_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk;
  logic            reset_all;
  logic            halt;
  logic [2:0]      req;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_data;
  logic [2:0]      gnt;
  logic            rb_we;
  logic [AW-1:0]   rb_waddr;
  logic [DW-1:0]   rb_wdata;
  logic [15:0]     wr_count;
  logic            idle;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [2:0]    mGnt;
  logic          mWe;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mData;
  logic [15:0]   mCount;
  int            mLast;

  rb_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset_all(reset_all),
    .halt     (halt),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .rb_we    (rb_we),
    .rb_waddr (rb_waddr),
    .rb_wdata (rb_wdata),
    .wr_count (wr_count),
    .idle     (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached got=running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    mGnt   = 3'b000;
    mWe    = 1'b0;
    mAddr  = '0;
    mData  = '0;
    mCount = 16'h0000;
    mLast  = 2;
  endtask

  // Predict the effect of the coming rising edge, then advance to just after it.
  task automatic tick();
    logic [2:0] eff;
    int w;
    eff = req & ~mGnt;
    w = -1;
    if (!halt) begin
      for (int k = 1; k <= 3; k++) begin
        int idx;
        idx = (mLast + k) % 3;
        if (w < 0 && eff[idx]) w = idx;
      end
    end
    if (w >= 0) begin
      mGnt  = 3'b000;
      mGnt[w] = 1'b1;
      mAddr = req_addr[w*AW +: AW];
      mData = req_data[w*DW +: DW];
      mWe   = (mAddr != 0);
      mLast = w;
      if (mWe) mCount = mCount + 16'd1;
    end else begin
      mGnt = 3'b000;
      mWe  = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic setReqs(input logic [2:0] r,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    req      = r;
    req_addr = {a2, a1, a0};
    req_data = {d2, d1, d0};
  endtask

  task automatic test_reset();
    reset_all = 1'b0;
    halt      = 1'b0;
    setReqs(3'b000, 0, 0, 0, 0, 0, 0);
    modelReset();
    #3;
    total++;
    if (gnt !== 3'b000 || rb_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_out gnt=%b we=%b want gnt=000 we=0", gnt, rb_we);
    end
    total++;
    if (rb_waddr !== '0 || rb_wdata !== '0 || wr_count !== 16'h0000) begin
      bad++;
      $display("FAIL reset_port addr=%0d data=%h cnt=%h want 0/0/0", rb_waddr, rb_wdata, wr_count);
    end
    total++;
    if (idle !== 1'b1) begin
      bad++;
      $display("FAIL reset_idle got=%b want=1", idle);
    end
    @(posedge clk);
    @(negedge clk);
    reset_all = 1'b1;
  endtask

  task automatic test_async_reset();
    setReqs(3'b001, 5'd4, 0, 0, 32'h1234, 0, 0);
    tick();
    total++;
    if (rb_we !== 1'b1 || gnt !== 3'b001 || wr_count !== 16'd1) begin
      bad++;
      $display("FAIL pre_reset_write we=%b gnt=%b cnt=%0d want we=1 gnt=001 cnt=1", rb_we, gnt, wr_count);
    end
    reset_all = 1'b0;
    modelReset();
    #2;
    total++;
    if (gnt !== 3'b000 || rb_we !== 1'b0 || wr_count !== 16'd0) begin
      bad++;
      $display("FAIL async_reset gnt=%b we=%b cnt=%0d want 000/0/0", gnt, rb_we, wr_count);
    end
    setReqs(3'b000, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_all = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [2:0]    expG [6];
    logic [AW-1:0] expA [6];
    logic [DW-1:0] expD [6];
    expG = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    expA = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    expD = '{32'hA, 32'hB, 32'hC, 32'hA, 32'hB, 32'hC};
    setReqs(3'b111, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC);
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (gnt !== expG[i] || rb_we !== 1'b1) begin
        bad++;
        $display("FAIL rr_gnt cyc=%0d got gnt=%b we=%b want gnt=%b we=1", i, gnt, rb_we, expG[i]);
      end
      total++;
      if (rb_waddr !== expA[i] || rb_wdata !== expD[i]) begin
        bad++;
        $display("FAIL rr_port cyc=%0d got addr=%0d data=%h want addr=%0d data=%h",
                 i, rb_waddr, rb_wdata, expA[i], expD[i]);
      end
    end
    total++;
    if (wr_count !== 16'd6) begin
      bad++;
      $display("FAIL rr_count got=%0d want=6", wr_count);
    end
  endtask

  task automatic test_single_requester();
    logic [15:0] c0;
    setReqs(3'b000, 0, 0, 0, 0, 0, 0);
    tick();
    c0 = mCount;
    setReqs(3'b001, 5'd4, 0, 0, 32'h1234, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (gnt !== ((i % 2 == 0) ? 3'b001 : 3'b000) || rb_we !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL single_gnt cyc=%0d got gnt=%b we=%b want alternating from 001/1", i, gnt, rb_we);
      end
      total++;
      if (wr_count !== c0 + 16'((i + 2) / 2)) begin
        bad++;
        $display("FAIL single_count cyc=%0d got=%0d want=%0d", i, wr_count, c0 + 16'((i + 2) / 2));
      end
    end
  endtask

  task automatic test_halt(input logic [2:0] expFirst);
    setReqs(3'b000, 0, 0, 0, 0, 0, 0);
    tick();
    halt = 1'b1;
    setReqs(3'b110, 0, 5'd7, 5'd9, 0, 32'h77, 32'h99);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (gnt !== 3'b000 || rb_we !== 1'b0) begin
        bad++;
        $display("FAIL halt_hold cyc=%0d got gnt=%b we=%b want 000/0", i, gnt, rb_we);
      end
    end
    halt = 1'b0;
    tick();
    total++;
    if (gnt !== expFirst || gnt !== mGnt) begin
      bad++;
      $display("FAIL halt_resume got=%b want=%b", gnt, expFirst);
    end
  endtask

  task automatic test_addr_zero();
    logic [15:0] c0;
    setReqs(3'b000, 0, 0, 0, 0, 0, 0);
    tick();
    c0 = wr_count;
    setReqs(3'b010, 0, 5'd0, 0, 0, 32'hFFFF_FFFF, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (gnt !== ((i % 2 == 0) ? 3'b010 : 3'b000) || rb_we !== 1'b0) begin
        bad++;
        $display("FAIL zero_gnt cyc=%0d got gnt=%b we=%b want %b/0", i, gnt, rb_we,
                 (i % 2 == 0) ? 3'b010 : 3'b000);
      end
      total++;
      if (wr_count !== c0 || wr_count !== mCount) begin
        bad++;
        $display("FAIL zero_count cyc=%0d got=%0d want=%0d", i, wr_count, mCount);
      end
    end
  endtask

  task automatic test_count_wrap();
    setReqs(3'b000, 0, 0, 0, 0, 0, 0);
    tick();
    force dut.r_wrCount = 16'hFFFE;
    #1;
    release dut.r_wrCount;
    #1;
    mCount = 16'hFFFE;
    total++;
    if (wr_count !== 16'hFFFE) begin
      bad++;
      $display("FAIL wrap_preload got=%h want=fffe", wr_count);
    end
    setReqs(3'b011, 5'd5, 5'd6, 0, 32'h55, 32'h66, 0);
    tick();
    total++;
    if (wr_count !== 16'hFFFF || rb_we !== 1'b1) begin
      bad++;
      $display("FAIL wrap_first got cnt=%h we=%b want ffff/1", wr_count, rb_we);
    end
    tick();
    total++;
    if (wr_count !== 16'h0000 || rb_we !== 1'b1) begin
      bad++;
      $display("FAIL wrap_second got cnt=%h we=%b want 0000/1", wr_count, rb_we);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [2:0] r;
      r = 3'($urandom_range(0, 7));
      halt = ($urandom_range(0, 5) == 0);
      setReqs(r, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              $urandom, $urandom, $urandom);
      #1;
      total++;
      if (idle !== ((mGnt == 3'b000) && ((req & ~mGnt) == 3'b000))) begin
        bad++;
        $display("FAIL rnd_idle cyc=%0d got=%b want=%b", i, idle,
                 (mGnt == 3'b000) && ((req & ~mGnt) == 3'b000));
      end
      tick();
      total++;
      if (gnt !== mGnt || rb_we !== mWe) begin
        bad++;
        $display("FAIL rnd_gnt cyc=%0d got gnt=%b we=%b want gnt=%b we=%b", i, gnt, rb_we, mGnt, mWe);
      end
      total++;
      if (rb_waddr !== mAddr || rb_wdata !== mData || wr_count !== mCount) begin
        bad++;
        $display("FAIL rnd_port cyc=%0d got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                 i, rb_waddr, rb_wdata, wr_count, mAddr, mData, mCount);
      end
    end
    halt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_round_robin();
    test_single_requester();
    test_halt(3'b010);
    test_halt(3'b100);
    test_addr_zero();
    test_count_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
